// File: rtl/mac_pkg.sv
// mac_pkg: shared types and helpers for the multiply-accumulate datapath.
// Holds mode/FSM enums and the product extension function.
package mac_pkg;

    typedef enum logic {
        MAC_FREE = 1'b0,
        MAC_DOT  = 1'b1
    } mac_mode_e;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } mac_state_e;

    localparam int MAC_MAX_W = 64;

    // Caller narrows the 64-bit result to its own accumulator width.
    function automatic logic [MAC_MAX_W-1:0] mac_ext(
        input logic [MAC_MAX_W-1:0] v,
        input int                   w,
        input logic                 sgn
    );
        logic [MAC_MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < MAC_MAX_W; i++) begin
            if (i >= w) begin
                r[i] = sgn ? v[w-1] : 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_if.sv
// mac_if: operand stream, result stream and control for mac_pipe.
// master drives operands/control, slave is the MAC unit.
interface mac_if #(
    parameter int N     = 4,
    parameter int ACC_W = 2*N+4,
    parameter int LEN   = 8
);
    logic                    clear;
    logic                    mode;
    logic                    in_valid;
    logic                    in_ready;
    logic [N-1:0]            a;
    logic [N-1:0]            b;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        result;
    logic                    sat;
    logic [$clog2(LEN)-1:0]  count;

    modport master (
        output clear, mode, in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, sat, count
    );

    modport slave (
        input  clear, mode, in_valid, a, b, out_ready,
        output in_ready, out_valid, result, sat, count
    );

endinterface

// File: rtl/mac_sat_add.sv
// mac_sat_add: W-bit adder with overflow flag and optional clamping.
// Signed overflow is judged on operand signs, unsigned on carry out.
module mac_sat_add #(
    parameter int W      = 10,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W:0]   raw;
    logic [W-1:0] maxv;
    logic [W-1:0] minv;

    always_comb begin
        raw = {1'b0, x} + {1'b0, y};
        if (SIGNED != 0) begin
            ovf  = (x[W-1] == y[W-1]) && (raw[W-1] != x[W-1]);
            maxv = {1'b0, {(W-1){1'b1}}};
            minv = {1'b1, {(W-1){1'b0}}};
        end else begin
            ovf  = raw[W];
            maxv = '1;
            minv = '0;
        end
        sum = raw[W-1:0];
        // Both operands negative means the true sum fell below min.
        if ((SAT != 0) && ovf) begin
            sum = ((SIGNED != 0) && x[W-1]) ? minv : maxv;
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined multiply-accumulate with handshakes.
// Free-running accumulate or LEN-product dot-product mode.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int N      = 4,
    parameter int ACC_W  = 2*N+4,
    parameter int LEN    = 8,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic clk,
    input  logic reset,
    mac_if.slave io
);
    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN-1);

    mac_mode_e      mode_q;
    mac_state_e     state_q;
    mac_state_e     state_d;
    logic [2*N-1:0] ax;
    logic [2*N-1:0] bx;
    logic [2*N-1:0] mul;
    logic [2*N-1:0] prod_q;
    logic           prod_v;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] res_q;
    logic [ACC_W-1:0] sum;
    logic           ovf;
    logic           sticky_q;
    logic           sat_q;
    logic           ov_q;
    logic [CW-1:0]  cnt_q;
    logic           advance;
    logic           accept;
    logic           step;
    logic           last;
    logic           emit;

    assign advance     = !(ov_q && !io.out_ready);
    assign io.in_ready = reset && advance && !io.clear;
    assign accept      = io.in_valid && io.in_ready;
    assign step        = prod_v && advance && !io.clear;
    assign last        = step && (mode_q == MAC_DOT)
                         && (cnt_q == LAST);
    assign emit        = step && ((mode_q == MAC_FREE) || last);

    // Low 2N bits of the product are exact once operands are extended.
    always_comb begin
        if (SIGNED != 0) begin
            ax = {{N{io.a[N-1]}}, io.a};
            bx = {{N{io.b[N-1]}}, io.b};
        end else begin
            ax = {{N{1'b0}}, io.a};
            bx = {{N{1'b0}}, io.b};
        end
        mul = ax * bx;
    end

    assign prod_ext = ACC_W'(mac_ext(
        {{(MAC_MAX_W-2*N){1'b0}}, prod_q}, 2*N, SIGNED != 0));

    mac_sat_add #(
        .W      (ACC_W),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_add (
        .x   (acc_q),
        .y   (prod_ext),
        .sum (sum),
        .ovf (ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else if (io.clear) begin
            prod_v <= 1'b0;
        end else if (advance) begin
            prod_v <= accept;
            if (accept) begin
                prod_q <= mul;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM: if (last) state_d = ST_EMIT;
            ST_EMIT:  state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
        if (io.clear) begin
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            mode_q   <= MAC_FREE;
        end else if (io.clear) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            mode_q   <= mac_mode_e'(io.mode);
        end else if (step) begin
            if (last) begin
                acc_q    <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end else begin
                acc_q    <= sum;
                sticky_q <= sticky_q | ovf;
                if (mode_q == MAC_DOT) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // A held result survives clear; only a consumer handshake drops it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ov_q  <= 1'b0;
            res_q <= '0;
            sat_q <= 1'b0;
        end else if (emit) begin
            ov_q  <= 1'b1;
            res_q <= sum;
            sat_q <= sticky_q | ovf;
        end else if (ov_q && io.out_ready) begin
            ov_q  <= 1'b0;
        end
    end

    assign io.out_valid = ov_q;
    assign io.result    = res_q;
    assign io.sat       = sat_q;
    assign io.count     = cnt_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed and randomized checks of mac_pipe, N=4 ACC_W=10 LEN=4.
// Unsigned and signed instances share stimulus; a queue model predicts results.
module tb_mac_pipe;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mac_if #(.N(4), .ACC_W(10), .LEN(4)) io_u ();
    mac_if #(.N(4), .ACC_W(10), .LEN(4)) io_s ();

    mac_pipe #(
        .N(4), .ACC_W(10), .LEN(4), .SIGNED(0), .SAT(1)
    ) dut_u (
        .clk   (clk),
        .reset (reset),
        .io    (io_u)
    );

    mac_pipe #(
        .N(4), .ACC_W(10), .LEN(4), .SIGNED(1), .SAT(1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .io    (io_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int         mu_acc;
    int         ms_acc;
    bit         mu_st;
    bit         ms_st;
    int         m_cnt;
    bit         m_dot;
    logic [10:0] qu[$];
    logic [10:0] qs[$];

    task automatic drive(input logic clr, input logic md,
                         input logic v, input logic [3:0] av,
                         input logic [3:0] bv, input logic rdy);
        io_u.clear = clr;  io_s.clear = clr;
        io_u.mode = md;    io_s.mode = md;
        io_u.in_valid = v; io_s.in_valid = v;
        io_u.a = av;       io_s.a = av;
        io_u.b = bv;       io_s.b = bv;
        io_u.out_ready = rdy;
        io_s.out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx4(input logic [3:0] x);
        return x[3] ? int'(x) - 16 : int'(x);
    endfunction

    task automatic model_clear(input bit dot);
        mu_acc = 0; ms_acc = 0;
        mu_st = 0;  ms_st = 0;
        m_cnt = 0;  m_dot = dot;
        qu.delete(); qs.delete();
    endtask

    task automatic model_accept(input logic [3:0] av, input logic [3:0] bv);
        mu_acc += int'(av) * int'(bv);
        ms_acc += sx4(av) * sx4(bv);
        if (mu_acc > 1023) begin mu_acc = 1023; mu_st = 1; end
        if (ms_acc > 511) begin ms_acc = 511; ms_st = 1; end
        if (ms_acc < -512) begin ms_acc = -512; ms_st = 1; end
        m_cnt++;
        if (!m_dot || m_cnt == 4) begin
            qu.push_back({mu_st, 10'(mu_acc)});
            qs.push_back({ms_st, 10'(ms_acc)});
        end
        if (m_dot && m_cnt == 4) begin
            mu_acc = 0; ms_acc = 0;
            mu_st = 0;  ms_st = 0;
            m_cnt = 0;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 1'b1);
        repeat (7) tick();
        n_cmp++;
        if (io_u.count !== 2'd2) begin
            n_err++;
            $display("FAIL rst_pre_cnt: got %0d want 2", io_u.count);
        end
        n_cmp++;
        if (io_u.result !== 10'd60) begin
            n_err++;
            $display("FAIL rst_pre_res: got %0d want 60", io_u.result);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (io_u.result !== 10'd0 || io_u.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out: got res=%0d ov=%b want 0/0",
                     io_u.result, io_u.out_valid);
        end
        n_cmp++;
        if (io_u.count !== 2'd0 || io_u.sat !== 1'b0) begin
            n_err++;
            $display("FAIL rst_cnt_sat: got cnt=%0d sat=%b want 0/0",
                     io_u.count, io_u.sat);
        end
        n_cmp++;
        if (io_u.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rdy: got %b want 0", io_u.in_ready);
        end
        tick();
        n_cmp++;
        if (io_u.in_ready !== 1'b0 || io_u.count !== 2'd0) begin
            n_err++;
            $display("FAIL rst_hold: got rdy=%b cnt=%0d want 0/0",
                     io_u.in_ready, io_u.count);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (io_u.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release: got rdy=%b want 1", io_u.in_ready);
        end
        // mode register must come back as free-running
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        n_cmp++;
        if (io_u.out_valid !== 1'b1 || io_u.result !== 10'd15) begin
            n_err++;
            $display("FAIL rst_mode: got ov=%b res=%0d want 1/15",
                     io_u.out_valid, io_u.result);
        end
        tick();
    endtask

    task automatic test_mode0();
        logic       eov [5];
        logic [9:0] eres[5];
        eov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        eres = '{10'd0, 10'd15, 10'd30, 10'd45, 10'd0};
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
            n_cmp++;
            if (io_u.out_valid !== eov[i] ||
                (eov[i] && io_u.result !== eres[i])) begin
                n_err++;
                $display("FAIL m0_beat%0d: got ov=%b res=%0d want %b/%0d",
                         i, io_u.out_valid, io_u.result, eov[i], eres[i]);
            end
        end
    endtask

    task automatic test_mode1();
        logic [3:0] av[4];
        logic [3:0] bv[4];
        logic [1:0] ecnt[4];
        av = '{4'd1, 4'd3, 4'd5, 4'd7};
        bv = '{4'd2, 4'd4, 4'd6, 4'd8};
        ecnt = '{2'd0, 2'd1, 2'd2, 2'd3};
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, av[i], bv[i], 1'b1);
            tick();
            n_cmp++;
            if (io_u.count !== ecnt[i] || io_u.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL m1_cnt%0d: got cnt=%0d ov=%b want %0d/0",
                         i, io_u.count, io_u.out_valid, ecnt[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        n_cmp++;
        if (io_u.out_valid !== 1'b1 || io_u.result !== 10'd100 ||
            io_u.sat !== 1'b0 || io_u.count !== 2'd0) begin
            n_err++;
            $display("FAIL m1_emit: got ov=%b res=%0d sat=%b cnt=%0d want 1/100/0/0",
                     io_u.out_valid, io_u.result, io_u.sat, io_u.count);
        end
        tick();
        n_cmp++;
        if (io_u.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL m1_pulse: got ov=%b want 0", io_u.out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [9:0] eres[5];
        eres = '{10'd225, 10'd450, 10'd675, 10'd900, 10'd1023};
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b1);
            else       drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (io_u.out_valid !== 1'b1 || io_u.result !== eres[i-1] ||
                    io_u.sat !== (i == 5)) begin
                    n_err++;
                    $display("FAIL sat_beat%0d: got ov=%b res=%0d sat=%b want 1/%0d/%b",
                             i, io_u.out_valid, io_u.result, io_u.sat,
                             eres[i-1], (i == 5));
                end
            end
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        n_cmp++;
        if (io_u.out_valid !== 1'b1 || io_u.result !== 10'd1 ||
            io_u.sat !== 1'b0) begin
            n_err++;
            $display("FAIL sat_clear: got ov=%b res=%0d sat=%b want 1/1/0",
                     io_u.out_valid, io_u.result, io_u.sat);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] av[5];
        logic [3:0] bv[5];
        av = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd2};
        bv = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd3};
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, av[i], bv[i], 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (io_u.in_ready !== 1'b0 || io_u.out_valid !== 1'b1 ||
                io_u.result !== 10'd100) begin
                n_err++;
                $display("FAIL bp_hold%0d: got rdy=%b ov=%b res=%0d want 0/1/100",
                         i, io_u.in_ready, io_u.out_valid, io_u.result);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        n_cmp++;
        if (io_u.out_valid !== 1'b0 || io_u.in_ready !== 1'b1 ||
            io_u.count !== 2'd1) begin
            n_err++;
            $display("FAIL bp_release: got ov=%b rdy=%b cnt=%0d want 0/1/1",
                     io_u.out_valid, io_u.in_ready, io_u.count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        n_cmp++;
        if (io_u.out_valid !== 1'b1 || io_u.result !== 10'd9) begin
            n_err++;
            $display("FAIL bp_next_vec: got ov=%b res=%0d want 1/9",
                     io_u.out_valid, io_u.result);
        end
        tick();
    endtask

    task automatic test_signed();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'hD, 4'd5, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'h8, 4'h8, 1'b1);
        tick();
        n_cmp++;
        if (io_s.out_valid !== 1'b1 || io_s.result !== 10'h3F1 ||
            io_s.sat !== 1'b0) begin
            n_err++;
            $display("FAIL sgn_neg: got ov=%b res=%h sat=%b want 1/3f1/0",
                     io_s.out_valid, io_s.result, io_s.sat);
        end
        n_cmp++;
        if (io_u.result !== 10'd65) begin
            n_err++;
            $display("FAIL sgn_u_first: got %0d want 65", io_u.result);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        n_cmp++;
        if (io_s.out_valid !== 1'b1 || io_s.result !== 10'd49 ||
            io_s.sat !== 1'b0) begin
            n_err++;
            $display("FAIL sgn_pos: got ov=%b res=%0d sat=%b want 1/49/0",
                     io_s.out_valid, io_s.result, io_s.sat);
        end
        n_cmp++;
        if (io_u.result !== 10'd129) begin
            n_err++;
            $display("FAIL sgn_u_second: got %0d want 129", io_u.result);
        end
        tick();
    endtask

    task automatic test_random(input bit dot, input int ncyc, input int amax);
        logic       v;
        logic       rdy;
        logic [3:0] av;
        logic [3:0] bv;
        logic [10:0] e;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        repeat (3) tick();
        drive(1'b1, dot, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        model_clear(dot);
        for (int c = 0; c < ncyc + 8; c++) begin
            if (c < ncyc) begin
                v   = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 9) < 7);
                av  = 4'($urandom_range(0, amax));
                bv  = 4'($urandom_range(0, amax));
            end else begin
                v = 1'b0; rdy = 1'b1; av = 4'd0; bv = 4'd0;
            end
            drive(1'b0, 1'b0, v, av, bv, rdy);
            #1;
            if (v && io_u.in_ready) model_accept(av, bv);
            if (io_u.out_valid && rdy) begin
                n_cmp++;
                if (qu.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_u_extra: got res=%0d want no result",
                             io_u.result);
                end else begin
                    e = qu.pop_front();
                    if ({io_u.sat, io_u.result} !== e) begin
                        n_err++;
                        $display("FAIL rnd_u: got sat=%b res=%0d want %b/%0d",
                                 io_u.sat, io_u.result, e[10], e[9:0]);
                    end
                end
            end
            if (io_s.out_valid && rdy) begin
                n_cmp++;
                if (qs.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_s_extra: got res=%h want no result",
                             io_s.result);
                end else begin
                    e = qs.pop_front();
                    if ({io_s.sat, io_s.result} !== e) begin
                        n_err++;
                        $display("FAIL rnd_s: got sat=%b res=%h want %b/%h",
                                 io_s.sat, io_s.result, e[10], e[9:0]);
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if (qu.size() != 0 || qs.size() != 0) begin
            n_err++;
            $display("FAIL rnd_left: got %0d/%0d pending want 0/0",
                     qu.size(), qs.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        test_reset();
        test_mode0();
        test_mode1();
        test_saturation();
        test_backpressure();
        test_signed();
        test_random(1'b1, 300, 15);
        test_random(1'b0, 150, 3);
        test_random(1'b0, 100, 15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
